// File: rtl/draw_scheduler.sv
// Round-robin arbiter for widget draw requests. It sends the granted client's window
// to the LCD path, then streams that client's pixels one at a time.
module draw_scheduler #(
  parameter int unsigned NCLIENTS = 4,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     enable,
  input  logic [NCLIENTS-1:0]      update,
  input  logic [NCLIENTS-1:0]      drawdone,
  input  logic [16*NCLIENTS-1:0]   xstart,
  input  logic [16*NCLIENTS-1:0]   xend,
  input  logic [16*NCLIENTS-1:0]   ystart,
  input  logic [16*NCLIENTS-1:0]   yend,
  input  logic [16*NCLIENTS-1:0]   color,
  output logic [NCLIENTS-1:0]      draw,
  output logic [NCLIENTS-1:0]      cnext,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [15:0]              win_x0,
  output logic [15:0]              win_x1,
  output logic [15:0]              win_y0,
  output logic [15:0]              win_y1,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [15:0]              pix_data,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned IW = $clog2(NCLIENTS);
  localparam int unsigned SW = $clog2(SETTLE + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StGrant, StWin, StSettle, StPix, StDoneWait, StRelease
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d, sel_q, sel_d;
  logic [NCLIENTS-1:0]  draw_q, draw_d, cnext_q, cnext_d;
  logic [15:0]          x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0]          pix_q, pix_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;

  logic [IW-1:0]        pick, pick_hi, pick_lo;
  logic                 any_hi, any_lo;
  logic [15:0]          sx0, sx1, sy0, sy1, scol;

  // Lowest requester at or above rr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    any_hi  = 1'b0;
    any_lo  = 1'b0;
    for (int i = NCLIENTS - 1; i >= 0; i--) begin
      if (update[i]) begin
        pick_lo = IW'(i);
        any_lo  = 1'b1;
        if (IW'(i) >= rr_q) begin
          pick_hi = IW'(i);
          any_hi  = 1'b1;
        end
      end
    end
    pick = any_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    sx0  = '0;
    sx1  = '0;
    sy0  = '0;
    sy1  = '0;
    scol = '0;
    for (int i = 0; i < NCLIENTS; i++) begin
      if (sel_q == IW'(i)) begin
        sx0  = xstart[16*i +: 16];
        sx1  = xend[16*i +: 16];
        sy0  = ystart[16*i +: 16];
        sy1  = yend[16*i +: 16];
        scol = color[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rr_q     <= '0;
      sel_q    <= '0;
      draw_q   <= '0;
      cnext_q  <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      pix_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      draw_q   <= draw_d;
      cnext_q  <= cnext_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      pix_q    <= pix_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    draw_d   = draw_q;
    cnext_d  = '0;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    pix_d    = pix_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && any_lo) begin
          sel_d   = pick;
          draw_d  = NCLIENTS'(1) << pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        x0_d  = sx0;
        x1_d  = sx1;
        y0_d  = sy0;
        y1_d  = sy1;
        cnt_d = (32'(sx1) - 32'(sx0) + 32'd1) * (32'(sy1) - 32'(sy0) + 32'd1);
        if (sx1 < sx0 || sy1 < sy0) begin
          err_d   = 1'b1;
          draw_d  = '0;
          state_d = StRelease;
        end else begin
          state_d = StWin;
        end
      end
      StWin: begin
        if (win_ready) begin
          settle_d = SW'(SETTLE);
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == '0) begin
          pix_d   = scol;
          state_d = StPix;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StPix: begin
        if (pix_ready) begin
          cnext_d = draw_q;
          cnt_d   = cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            tmo_d   = '0;
            state_d = StDoneWait;
          end else begin
            settle_d = SW'(SETTLE);
            state_d  = StSettle;
          end
        end
      end
      StDoneWait: begin
        // First cycle overlaps the final cnext, so drawdone is stale there.
        tmo_d = tmo_q + 1'b1;
        if (tmo_q != '0 && (|(drawdone & draw_q))) begin
          draw_d  = '0;
          state_d = StRelease;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          draw_d  = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        rr_d    = (sel_q == IW'(NCLIENTS - 1)) ? '0 : sel_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    win_valid = (state_q == StWin);
    pix_valid = (state_q == StPix);
    busy      = (state_q != StIdle);
    draw      = draw_q;
    cnext     = cnext_q;
    win_x0    = x0_q;
    win_x1    = x1_q;
    win_y0    = y0_q;
    win_y1    = y1_q;
    pix_data  = pix_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized bench for draw_scheduler. Clients are modelled behaviourally, and a
// transaction-level monitor predicts grants, pixel streams and release timing.
module tb_draw_scheduler;

  localparam int NC  = 4;
  localparam int STL = 2;
  localparam int TMO = 64;

  logic              clk;
  logic              arstn;
  logic              enable;
  logic [NC-1:0]     update, drawdone, draw, cnext;
  logic [16*NC-1:0]  xstart, xend, ystart, yend, color;
  logic              win_valid, win_ready, pix_valid, pix_ready, busy, err;
  logic [15:0]       win_x0, win_x1, win_y0, win_y1, pix_data;

  draw_scheduler #(.NCLIENTS(NC), .SETTLE(STL), .TIMEOUT(TMO)) dut (
    .clk(clk), .arstn(arstn), .enable(enable), .update(update), .drawdone(drawdone),
    .xstart(xstart), .xend(xend), .ystart(ystart), .yend(yend), .color(color),
    .draw(draw), .cnext(cnext), .win_valid(win_valid), .win_ready(win_ready),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Client-side state
  logic [15:0] wx0[NC], wx1[NC], wy0[NC], wy1[NC];
  bit          hang[NC];
  int          pc[NC];

  function automatic int win_pix(logic [15:0] x0, logic [15:0] x1, logic [15:0] y0,
                                 logic [15:0] y1);
    if (x1 < x0 || y1 < y0) return 0;
    return (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
  endfunction

  function automatic logic [15:0] colour(int c, int k);
    return 16'((c + 1) * 4096 + c * 7 + k * 97);
  endfunction

  function automatic logic [NC-1:0] onehot(int c);
    return NC'(1) << c;
  endfunction

  function automatic int rr_pick(logic [NC-1:0] u, int rr);
    for (int k = 0; k < NC; k++) begin
      if (u[(rr + k) % NC]) return (rr + k) % NC;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (!draw[i]) pc[i] <= 0;
      else if (cnext[i]) pc[i] <= pc[i] + 1;
    end
  end

  always_comb begin
    xstart = '0; xend = '0; ystart = '0; yend = '0; color = '0; drawdone = '0;
    for (int i = 0; i < NC; i++) begin
      xstart[16*i +: 16] = wx0[i];
      xend[16*i +: 16]   = wx1[i];
      ystart[16*i +: 16] = wy0[i];
      yend[16*i +: 16]   = wy1[i];
      color[16*i +: 16]  = colour(i, pc[i]);
      drawdone[i] = !draw[i] || (!hang[i] && pc[i] >= win_pix(wx0[i], wx1[i], wy0[i], wy1[i]));
    end
  end

  // Transaction monitor: 0 idle, 1 grant expected, 2 transaction active
  int          phase = 0, rr_m = 0, exp_c = 0, cur = 0, ncyc = 0;
  int          n_txn = 0, n_errc = 0, pix_n = 0, cn_n = 0, wv_n = 0, wh_n = 0;
  int          t_grant = 0, t_cn = 0, e_npix = 0;
  bit          e_inv, e_hang;
  logic [63:0] e_win;
  logic        p_pv, p_pr, p_wv, p_wr, p_cn;
  logic [15:0] p_pd;
  int          glog[$];

  always @(negedge clk) begin
    if (!arstn) begin
      phase = 0; rr_m = 0;
      p_pv = 0; p_pr = 0; p_wv = 0; p_wr = 0; p_cn = 0; p_pd = '0;
    end else begin
      ncyc++;
      if (err) n_errc++;
      case (phase)
        0: begin
          check_eq("idle_outs", {busy, err, win_valid, pix_valid, draw, cnext}, 0);
          if (enable && update != '0) begin
            exp_c = rr_pick(update, rr_m);
            phase = 1;
          end
        end
        1: begin
          check_eq("grant", draw, onehot(exp_c));
          glog.push_back(exp_c);
          cur = exp_c; t_grant = ncyc;
          pix_n = 0; cn_n = 0; wv_n = 0; wh_n = 0;
          e_inv  = (wx1[cur] < wx0[cur]) || (wy1[cur] < wy0[cur]);
          e_npix = win_pix(wx0[cur], wx1[cur], wy0[cur], wy1[cur]);
          e_hang = hang[cur];
          e_win  = {wx0[cur], wx1[cur], wy0[cur], wy1[cur]};
          phase = 2;
        end
        default: begin
          if (draw == '0) begin
            check_eq("rel_busy", busy, 1);
            check_eq("pix_count", pix_n, e_npix);
            check_eq("cnext_count", cn_n, e_npix);
            check_eq("win_hs", wh_n, e_inv ? 0 : 1);
            check_eq("win_req", wv_n != 0, !e_inv);
            check_eq("err_pulse", err, e_inv || e_hang);
            check_eq("rel_delay", e_inv ? ncyc - t_grant : ncyc - t_cn,
                     e_inv ? 1 : (e_hang ? TMO : 2));
            rr_m = (cur + 1) % NC;
            n_txn++;
            phase = 0;
          end else begin
            check_eq("draw_hold", {err, draw}, {1'b0, onehot(cur)});
            if (win_valid) wv_n++;
            if (win_valid && win_ready) begin
              wh_n++;
              check_eq("win_rect", {win_x0, win_x1, win_y0, win_y1}, e_win);
            end
            if (p_wv && !p_wr) check_eq("win_hold", win_valid, 1);
            if (p_pv && !p_pr) check_eq("pix_hold", {pix_valid, pix_data}, {1'b1, p_pd});
            if (pix_valid && pix_ready) begin
              check_eq("pix_data", pix_data, colour(cur, pix_n));
              pix_n++;
            end
            if (cnext != '0) begin
              check_eq("cnext", {p_cn, cnext}, {1'b0, onehot(cur)});
              cn_n++;
              t_cn = ncyc;
            end
          end
        end
      endcase
      p_pv = pix_valid; p_pr = pix_ready; p_pd = pix_data;
      p_wv = win_valid; p_wr = win_ready; p_cn = |cnext;
    end
  end

  // Stimulus
  bit rdy_rand = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) begin
      win_ready = ($urandom % 3) != 0;
      pix_ready = ($urandom % 3) != 0;
    end
  endtask

  task automatic set_win(input int c, input int x0, input int x1, input int y0, input int y1,
                         input bit h);
    wx0[c] = 16'(x0); wx1[c] = 16'(x1); wy0[c] = 16'(y0); wy1[c] = 16'(y1); hang[c] = h;
  endtask

  task automatic rand_win(input int c);
    int x0 = 1 + int'($urandom % 40);
    int y0 = int'($urandom % 40);
    if ($urandom % 10 == 0) set_win(c, x0, x0 - 1, y0, y0, 0);
    else set_win(c, x0, x0 + int'($urandom % 4), y0, y0 + int'($urandom % 3),
                 ($urandom % 12) == 0);
  endtask

  task automatic do_reset();
    arstn = 0; update = '0; enable = 1; win_ready = 1; pix_ready = 1; rdy_rand = 0;
    for (int c = 0; c < NC; c++) set_win(c, 0, 0, 0, 0, 0);
    step();
    step();
    check_eq("rst_ctl", {busy, err, win_valid, pix_valid, draw, cnext}, 0);
    check_eq("rst_data", {pix_data, win_x0, win_x1, win_y0}, 0);
    check_eq("rst_y1", win_y1, 0);
    glog.delete();
    arstn = 1;
    step();
  endtask

  task automatic wait_txn(input int target, input int budget, input string tag);
    int n = 0;
    while (n_txn < target && n < budget) begin step(); n++; end
    check_eq(tag, n_txn >= target, 1);
  endtask

  int base, e0, n;
  int t2_exp[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // 1: single client, 10x2 window
    do_reset();
    set_win(2, 10, 19, 5, 6, 0);
    base = n_txn; update = 4'b0100;
    wait_txn(base + 1, 400, "t1_done");
    update = '0;
    check_eq("t1_grant", glog[0], 2);

    // 2: round-robin order with continuous requests
    do_reset();
    set_win(0, 1, 1, 1, 1, 0); set_win(1, 2, 2, 2, 2, 0); set_win(3, 3, 3, 3, 3, 0);
    base = n_txn; update = 4'b1011;
    wait_txn(base + 6, 300, "t2_done");
    update = '0;
    check_eq("t2_count", glog.size() >= 6, 1);
    for (int k = 0; k < 6; k++) check_eq("t2_order", glog[k], t2_exp[k]);

    // 3: pixel stall on second pixel
    do_reset();
    set_win(1, 0, 1, 0, 1, 0);
    base = n_txn; update = 4'b0010;
    n = 0;
    while (!(phase == 2 && pix_n >= 1) && n < 100) begin step(); n++; end
    check_eq("t3_pix1", pix_n, 1);
    pix_ready = 0;
    n = 0;
    while (!pix_valid && n < 50) begin step(); n++; end
    check_eq("t3_stall_reach", pix_valid, 1);
    repeat (5) step();
    pix_ready = 1;
    wait_txn(base + 1, 200, "t3_done");
    update = '0;

    // 4: inverted window raises err, next requester follows
    do_reset();
    set_win(0, 8, 3, 0, 0, 0); set_win(1, 4, 4, 4, 4, 0);
    base = n_txn; e0 = n_errc; update = 4'b0011;
    wait_txn(base + 2, 200, "t4_done");
    update = '0;
    check_eq("t4_order0", glog[0], 0);
    check_eq("t4_order1", glog[1], 1);
    check_eq("t4_errs", n_errc - e0, 1);

    // 5: client never reports drawdone
    do_reset();
    set_win(2, 0, 1, 0, 0, 1);
    base = n_txn; update = 4'b0100;
    n = 0;
    while (draw == '0 && n < 20) begin step(); n++; end
    check_eq("t5_grant", draw, 4'b0100);
    update = '0;
    wait_txn(base + 1, TMO + 100, "t5_done");
    step();
    check_eq("t5_idle", {busy, draw}, 0);

    // 6: asynchronous reset mid-stream
    do_reset();
    set_win(0, 0, 0, 0, 0, 0); set_win(3, 0, 4, 0, 3, 0);
    base = n_txn; update = 4'b0001;
    wait_txn(base + 1, 100, "t6_first");
    update = 4'b1000;
    n = 0;
    while (!(phase == 2 && cur == 3 && pix_n >= 6) && n < 400) begin step(); n++; end
    check_eq("t6_pix6", pix_n, 6);
    pix_ready = 0;
    n = 0;
    while (!pix_valid && n < 50) begin step(); n++; end
    check_eq("t6_in_pix", pix_valid, 1);
    update = 4'b1011;
    #2 arstn = 0;
    #1 check_eq("t6_async", {busy, win_valid, pix_valid, draw, cnext}, 0);
    step();
    step();
    pix_ready = 1;
    base = n_txn; glog.delete();
    arstn = 1;
    wait_txn(base + 1, 100, "t6_regrant");
    update = '0;
    check_eq("t6_rr0", glog[0], 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < NC; c++) rand_win(c);
    rdy_rand = 1; base = n_txn;
    for (int k = 0; k < 4000; k++) begin
      step();
      if ($urandom % 8 == 0) update = NC'($urandom);
      if ($urandom % 16 == 0) enable = ($urandom % 6) != 0;
      for (int c = 0; c < NC; c++) if (!draw[c] && $urandom % 32 == 0) rand_win(c);
    end
    rdy_rand = 0;
    check_eq("rand_progress", n_txn - base >= 15, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
